// File: rtl/round_sequencer.sv
// Round controller for the gold-miner game: arms and runs the countdown timer,
// gates hook launches, and decides level advance, win or loss at time-out.
module round_sequencer #(
    parameter int NUM_LEVELS  = 4,
    parameter int SCORE_W     = 12,
    parameter int TARGET_BASE = 100,
    parameter int TARGET_STEP = 50
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               pause,
    input  logic               time_up,
    input  logic               hook_busy,
    input  logic [SCORE_W-1:0] score,
    output logic               timer_enable,
    output logic               time_resetn,
    output logic               move_enable,
    output logic               score_clear,
    output logic               level_pass,
    output logic [2:0]         level,
    output logic [SCORE_W-1:0] target,
    output logic               game_win,
    output logic               game_over,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSE  = 3'd3,
        S_SETTLE = 3'd4,
        S_CHECK  = 3'd5,
        S_WIN    = 3'd6,
        S_LOSE   = 3'd7
    } state_t;

    localparam int         TW         = SCORE_W + 4;
    localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);

    // Widened sum so a large base or step saturates instead of wrapping.
    function automatic logic [SCORE_W-1:0] level_target(input logic [2:0] lvl);
        logic [TW-1:0] sum;
        sum = TW'(TARGET_BASE) + TW'(lvl) * TW'(TARGET_STEP);
        if (|sum[TW-1:SCORE_W])
            return '1;
        return sum[SCORE_W-1:0];
    endfunction

    state_t state_q;
    state_t state_d;
    logic   level_clr;
    logic   level_inc;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        level_clr = 1'b0;
        level_inc = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d   = S_ARM;
                    level_clr = 1'b1;
                end
            end
            S_ARM:   state_d = S_PLAY;
            S_PLAY: begin
                if (time_up)
                    state_d = S_SETTLE;
                else if (pause)
                    state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause)
                    state_d = S_PLAY;
            end
            S_SETTLE: begin
                if (!hook_busy)
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (score >= target) begin
                    if (level == LAST_LEVEL) begin
                        state_d = S_WIN;
                    end else begin
                        state_d   = S_ARM;
                        level_inc = 1'b1;
                    end
                end else begin
                    state_d = S_LOSE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Outputs decode the next state so they switch on the same edge as state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level        <= 3'd0;
            target       <= level_target(3'd0);
            timer_enable <= 1'b0;
            move_enable  <= 1'b0;
            time_resetn  <= 1'b0;
            score_clear  <= 1'b0;
            level_pass   <= 1'b0;
            game_win     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            if (level_clr)
                level <= 3'd0;
            else if (level_inc)
                level <= level + 3'd1;
            target       <= level_target(level);
            timer_enable <= (state_d == S_PLAY);
            move_enable  <= (state_d == S_PLAY);
            time_resetn  <= !((state_d == S_IDLE) || (state_d == S_ARM));
            score_clear  <= level_clr;
            level_pass   <= level_inc;
            game_win     <= (state_d == S_WIN);
            game_over    <= (state_d == S_LOSE);
        end
    end

    assign state = state_q;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller that sequences the countdown timer and gates player movement for the gold-miner game. It arms and reloads the timer, runs and pauses it, and waits for the hook to settle after time-out. It then compares the score against a per-level target and advances the level, declares a win, or declares a loss. It sits between the top-level input/FSM glue and the timer/score datapath.

## Interface
- NUM_LEVELS, 4, number of levels; the last level index is NUM_LEVELS-1.
- SCORE_W, 12, score and target width.
- TARGET_BASE, 100, score target for level 0.
- TARGET_STEP, 50, target increment per level.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start request.
- pause  in  1  one-cycle pause-toggle request.
- time_up  in  1  high when the timer's remaining time is 0.
- hook_busy  in  1  high while the hook is extended or retracting.
- score  in  SCORE_W  current score.
- timer_enable  out  1  lets the timer count down.
- time_resetn  out  1  active-low timer reload; driven directly by a flop.
- move_enable  out  1  player may launch the hook.
- score_clear  out  1  one-cycle pulse that clears the score at new-game start.
- level_pass  out  1  one-cycle pulse when a level is cleared.
- level  out  3  current level index.
- target  out  SCORE_W  score target for the current level.
- game_win  out  1  high while in WIN.
- game_over  out  1  high while in LOSE.
- state  out  3  state code, for debug and VGA.

## Operation
- States and codes: IDLE=0, ARM=1, PLAY=2, PAUSE=3, SETTLE=4, CHECK=5, WIN=6, LOSE=7.
- IDLE: start -> ARM. On this transition level is set to 0 and score_clear pulses.
- ARM: lasts exactly 1 cycle, then -> PLAY.
- PLAY: the first matching condition wins:
  - time_up -> SETTLE. time_up has priority over a simultaneous pause.
  - pause -> PAUSE.
- PAUSE: pause -> PLAY. time_up is ignored.
- SETTLE: waits until hook_busy=0, then -> CHECK. If hook_busy is already 0, it stays 1 cycle.
- CHECK: lasts 1 cycle.
  - If score >= target and level == NUM_LEVELS-1 -> WIN.
  - If score >= target otherwise -> ARM, level increments, level_pass pulses.
  - If score < target -> LOSE.
  - The comparison is unsigned.
- WIN and LOSE: start -> ARM. On this transition level is set to 0 and score_clear pulses.
- start is ignored in ARM, PLAY, PAUSE, SETTLE and CHECK.
- Output decode (Moore; registered from next-state, so outputs change on the same edge as state):
  - timer_enable=1 only in PLAY.
  - move_enable=1 only in PLAY.
  - time_resetn=0 in IDLE and ARM, 1 in all other states. The timer therefore holds its reload value until PLAY, and holds its final value in WIN and LOSE.
  - game_win=1 in WIN. game_over=1 in LOSE.
- target = TARGET_BASE + level*TARGET_STEP.
  - Computed in SCORE_W+4 bits.
  - Saturates to all-ones if the result overflows SCORE_W.
  - Registered; updates on the cycle after level changes, and is therefore valid before CHECK.

## Timing
- Reset values: state=IDLE, level=0, target=TARGET_BASE, time_resetn=0, and every other output 0.
- Asynchronous reset mid-round: all registers return to their reset values immediately. Because time_resetn drops, the timer reloads.
- start to first countdown enable: start sampled at edge N gives ARM at N; PLAY and timer_enable=1 at N+1.
- time_up sampled at edge N in PLAY gives timer_enable=0 and move_enable=0 at N. The timer performs no further decrement.
- Level transition: CHECK at edge N gives ARM at N+1 (time_resetn low for 1 cycle) and PLAY at N+2.
- score_clear and level_pass are high for exactly one cycle each.
- Inputs are synchronous to clk. No input is held or queued across states; an event arriving in a state that does not use it is lost.

## Test plan
- Reset mid-PLAY, then release -> state=0, time_resetn=0, level=0, target=100, all other outputs 0.
- start; hold score=120; assert time_up with hook_busy=0 (NUM_LEVELS=2) -> SETTLE 1 cycle, CHECK, then level_pass pulse, level=1, target=150, ARM for 1 cycle, then PLAY.
- At level 1, score=150, time_up -> WIN, game_win=1. Then start -> score_clear pulse, level=0.
- PLAY with score=99 and time_up while hook_busy=1 for 5 cycles -> SETTLE held 5 cycles with move_enable=0, then CHECK -> LOSE, game_over=1.
- pause and time_up in the same cycle in PLAY -> SETTLE, not PAUSE. Separately: pause twice -> PLAY-PAUSE-PLAY, timer_enable 1-0-1, and time_up is ignored while in PAUSE.
- TARGET_BASE=4000, TARGET_STEP=50, SCORE_W=12, level 2 -> target=4095 (saturated).
